pipeline_elastic: RTL and testbench

// - Parametrised successor to our fixed-delay register chain: STAGES-deep data pipeline with per-stage valid bits,

---
 rtl/pipeline_elastic_if.sv | 22 ++
 rtl/pipeline_elastic.sv | 67 ++++++
 tb/tb_pipeline_elastic.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_elastic_if.sv
// Valid/ready/data handshake bundle used on both ends of the elastic pipeline.
interface pipeline_elastic_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    // Producer side of a link
    modport master (
        output valid,
        output data,
        input  ready
    );

    // Consumer side of a link
    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipeline_elastic.sv
// STAGES-deep elastic data pipeline: per-stage valid bits, valid/ready at both ends, bubble
// collapsing under backpressure, synchronous flush and a registered occupancy count.
module pipeline_elastic #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    pipeline_elastic_if.slave            in_if,
    pipeline_elastic_if.master           out_if,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);
    localparam int unsigned OW = $clog2(STAGES + 1);

    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [OW-1:0]     occ_q;

    // r[i]: stage i can take a beat this cycle. Kept as an unpacked array so each link of the
    // chain is its own net.
    logic              r [STAGES+1];
    logic              in_fire;
    logic              out_fire;

    assign r[STAGES] = out_if.ready;

    for (genvar i = 0; i < int'(STAGES); i++) begin : g_ready
        // Empty stage always accepts; full stage accepts only if its beat moves on
        assign r[i] = ~v_q[i] | r[i+1];
    end

    assign in_if.ready  = r[0] & ~flush;
    assign out_if.valid = v_q[STAGES-1] & ~flush;
    assign out_if.data  = d_q[STAGES-1];
    assign occupancy    = occ_q;

    assign in_fire  = in_if.valid & in_if.ready;
    assign out_fire = out_if.valid & out_if.ready;

    // Stage advance, flush and occupancy tracking; flush wins over any transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                d_q[i] <= '0;
            end
        end else if (flush) begin
            // Data left stale on purpose; valid bits alone define content
            v_q   <= '0;
            occ_q <= '0;
        end else begin
            if (r[0]) begin
                v_q[0] <= in_if.valid;
                d_q[0] <= in_if.data;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (r[i]) begin
                    v_q[i] <= v_q[i-1];
                    d_q[i] <= d_q[i-1];
                end
            end
            occ_q <= occ_q + OW'(in_fire) - OW'(out_fire);
        end
    end
endmodule

// File: tb/tb_pipeline_elastic.sv
// Bench for pipeline_elastic: directed scenarios on a 3-stage instance, plus randomized
// scoreboard runs on 1- and 4-stage instances.
module tb_pipeline_elastic;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks       = 0;
    int failures     = 0;
    int rnd_finished = 0;

    logic rst_a;
    logic rst_b;
    logic flush_a;
    logic [1:0] occ_a;

    pipeline_elastic_if #(.WIDTH(W)) a_in ();
    pipeline_elastic_if #(.WIDTH(W)) a_out ();

    pipeline_elastic #(.WIDTH(W), .STAGES(3)) u_a (
        .clk       (clk),
        .rst       (rst_a),
        .flush     (flush_a),
        .in_if     (a_in),
        .out_if    (a_out),
        .occupancy (occ_a)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One cycle on the directed instance: wait for an edge, drive inputs, let them settle
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        a_in.valid  = v;
        a_in.data   = d;
        a_out.ready = ordy;
        flush_a     = fl;
        #1;
    endtask

    task automatic chk_out(input string name, input logic exp_v, input logic [W-1:0] exp_d);
        chk({name, " valid"}, 32'(a_out.valid), 32'(exp_v));
        if (exp_v) chk({name, " data"}, 32'(a_out.data), 32'(exp_d));
    endtask

    // Watchdog so a stuck run still ends
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // Directed scenarios, then wait for the random runs and report
    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        flush_a = 1'b0;
        a_in.valid = 1'b0;
        a_in.data = '0;
        a_out.ready = 1'b0;
        #1;
        chk("reset out_valid", 32'(a_out.valid), 32'd0);
        chk("reset out_data", 32'(a_out.data), 32'd0);
        chk("reset occupancy", 32'(occ_a), 32'd0);
        #21;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("reset in_ready", 32'(a_in.ready), 32'd1);

        // Streaming 0x01..0x0A with out_ready held high
        for (int c = 0; c < 14; c++) begin
            cyc(c < 10, W'(c + 1), 1'b1, 1'b0);
            if (c >= 3 && c <= 12) chk_out("stream", 1'b1, W'(c - 2));
            else chk_out("stream idle", 1'b0, '0);
            if (c >= 3 && c <= 10) chk("stream occupancy", 32'(occ_a), 32'd3);
        end

        // Backpressure on a full pipeline, then simultaneous in/out
        cyc(1'b1, 8'hA1, 1'b0, 1'b0);
        cyc(1'b1, 8'hA2, 1'b0, 1'b0);
        cyc(1'b1, 8'hA3, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            chk("bp in_ready", 32'(a_in.ready), 32'd0);
            chk("bp occupancy", 32'(occ_a), 32'd3);
            chk_out("bp hold", 1'b1, 8'hA1);
        end
        cyc(1'b1, 8'hA4, 1'b1, 1'b0);
        chk("bp release in_ready", 32'(a_in.ready), 32'd1);
        chk_out("bp release", 1'b1, 8'hA1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("bp both occupancy", 32'(occ_a), 32'd3);
        chk_out("bp drain A2", 1'b1, 8'hA2);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_out("bp drain A3", 1'b1, 8'hA3);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_out("bp drain A4", 1'b1, 8'hA4);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_out("bp empty", 1'b0, '0);
        chk("bp empty occupancy", 32'(occ_a), 32'd0);

        // Bubble collapse: 0x11, gap, 0x22 under a stalled output
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("bubble occupancy", 32'(occ_a), 32'd2);
        chk("bubble in_ready", 32'(a_in.ready), 32'd1);
        chk_out("bubble first", 1'b1, 8'h11);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_out("bubble second", 1'b1, 8'h22);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_out("bubble empty", 1'b0, '0);

        // Flush with a beat offered and the output ready
        cyc(1'b1, 8'h31, 1'b0, 1'b0);
        cyc(1'b1, 8'h32, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b1, 1'b1);
        chk("flush pre occupancy", 32'(occ_a), 32'd2);
        chk("flush in_ready", 32'(a_in.ready), 32'd0);
        chk("flush out_valid", 32'(a_out.valid), 32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("flush post occupancy", 32'(occ_a), 32'd0);
        chk("flush post in_ready", 32'(a_in.ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            chk_out("flush nothing left", 1'b0, '0);
            cyc(1'b0, '0, 1'b1, 1'b0);
        end

        // Asynchronous reset between edges with a full pipeline
        cyc(1'b1, 8'hB1, 1'b0, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0, 1'b0);
        cyc(1'b1, 8'hB3, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("prereset occupancy", 32'(occ_a), 32'd3);
        #3;
        rst_a = 1'b1;
        #1;
        chk("async rst out_valid", 32'(a_out.valid), 32'd0);
        chk("async rst out_data", 32'(a_out.data), 32'd0);
        chk("async rst occupancy", 32'(occ_a), 32'd0);
        #2;
        rst_a = 1'b0;
        cyc(1'b1, 8'hC1, 1'b1, 1'b0);
        chk("post rst in_ready", 32'(a_in.ready), 32'd1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_out("post rst lat1", 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_out("post rst lat2", 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_out("post rst lat3", 1'b1, 8'hC1);

        wait (rnd_finished == 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    for (genvar g = 0; g < 2; g++) begin : g_rnd
        localparam int unsigned S  = (g == 0) ? 1 : 4;
        localparam int unsigned OW = $clog2(S + 1);

        logic          flush_r;
        logic [OW-1:0] occ_r;
        logic [W-1:0]  exp_q [$];

        pipeline_elastic_if #(.WIDTH(W)) r_in ();
        pipeline_elastic_if #(.WIDTH(W)) r_out ();

        pipeline_elastic #(.WIDTH(W), .STAGES(S)) u_r (
            .clk       (clk),
            .rst       (rst_b),
            .flush     (flush_r),
            .in_if     (r_in),
            .out_if    (r_out),
            .occupancy (occ_r)
        );

        // Random stimulus; accepted beats go to the scoreboard, flush empties it
        initial begin
            r_in.valid  = 1'b0;
            r_in.data   = '0;
            r_out.ready = 1'b0;
            flush_r     = 1'b0;
            #30;
            for (int n = 0; n < 2000; n++) begin
                @(posedge clk);
                #1;
                r_in.valid  = ($urandom_range(0, 99) < 70);
                r_in.data   = W'($urandom);
                r_out.ready = ($urandom_range(0, 99) < 60);
                flush_r     = ($urandom_range(0, 99) < 5);
                @(negedge clk);
                chk("rnd occupancy", 32'(occ_r), 32'(exp_q.size()));
                chk("rnd occupancy bound", 32'(occ_r <= OW'(S)), 32'd1);
                chk("rnd in_ready", 32'(r_in.ready),
                    32'(!flush_r && (exp_q.size() < int'(S) || r_out.ready)));
                if (flush_r) exp_q.delete();
                else if (r_in.valid && r_in.ready) exp_q.push_back(r_in.data);
            end
            @(posedge clk);
            #1;
            r_in.valid  = 1'b0;
            r_out.ready = 1'b1;
            flush_r     = 1'b0;
            repeat (S + 3) @(posedge clk);
            @(negedge clk);
            chk("rnd drained queue", 32'(exp_q.size()), 32'd0);
            chk("rnd drained occupancy", 32'(occ_r), 32'd0);
            rnd_finished++;
        end

        // Output monitor: every delivered beat must be the oldest outstanding one
        initial begin
            forever begin
                @(negedge clk);
                #1;
                if (r_out.valid && r_out.ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rnd unexpected beat: got 0x%0h expected none (S=%0d)",
                                 r_out.data, S);
                    end else begin
                        chk("rnd out data", 32'(r_out.data), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end
endmodule
